// File: rtl/i2c_recv.sv
// I2C master-receive data phase: clocks in 1-16 bytes from a slave, ACKs every
// byte but the last and NACKs the last. SCL edges come from external strobes.
module i2c_recv (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_posedge,
  input  logic       scl_negedge,
  input  logic       start,
  input  logic [3:0] recv_cnt,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] rx_index,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_BIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_last_idx;
  logic [CNT_W-1:0]    r_byte_idx;
  logic [CNT_W-1:0]    r_rx_index;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [BYTE_W-1:0]   r_shift;
  logic [BYTE_W-1:0]   r_rx_data;
  logic                r_sample_pending;
  logic                r_busy;
  logic                r_done;
  logic                r_rx_valid;
  logic                r_scl;
  logic                r_sda_oe;

  logic                w_pos;
  logic                w_sda_in;
  logic [BYTE_W-1:0]   w_shift_nxt;

  // Simultaneous strobes: the falling edge wins.
  assign w_pos    = scl_posedge & ~scl_negedge;
  // Released line reads as 1 through the bus pull-up.
  assign w_sda_in = sda;
  assign sda      = r_sda_oe ? 1'b0 : 1'bz;

  // Shift register with any pending sample folded in.
  always_comb begin
    w_shift_nxt = r_shift;
    if (r_sample_pending) begin
      w_shift_nxt[r_bit_cnt] = w_sda_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_last_idx       <= '0;
      r_byte_idx       <= '0;
      r_rx_index       <= '0;
      r_bit_cnt        <= '0;
      r_shift          <= '0;
      r_rx_data        <= '0;
      r_sample_pending <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_rx_valid       <= 1'b0;
      r_scl            <= 1'b1;
      r_sda_oe         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last_idx <= recv_cnt;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (scl_negedge) begin
            r_scl            <= 1'b0;
            r_sda_oe         <= 1'b0;
            r_bit_cnt        <= BIT_W'(7);
            r_sample_pending <= 1'b0;
            r_state          <= S_BIT;
          end
        end
        S_BIT: begin
          r_shift          <= w_shift_nxt;
          r_sample_pending <= 1'b0;
          if (w_pos) begin
            r_scl            <= 1'b1;
            r_sample_pending <= 1'b1;
          end else if (scl_negedge) begin
            r_scl <= 1'b0;
            if (r_bit_cnt != '0) begin
              r_bit_cnt <= r_bit_cnt - BIT_W'(1);
            end else begin
              r_rx_data  <= w_shift_nxt;
              r_rx_index <= r_byte_idx;
              r_rx_valid <= 1'b1;
              r_sda_oe   <= (r_byte_idx < r_last_idx);
              r_state    <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (w_pos) begin
            r_scl <= 1'b1;
          end else if (scl_negedge) begin
            r_scl    <= 1'b0;
            r_sda_oe <= 1'b0;
            if (r_byte_idx == r_last_idx) begin
              // done/busy are registered so they show while in DONE.
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_byte_idx <= r_byte_idx + CNT_W'(1);
              r_bit_cnt  <= BIT_W'(7);
              r_state    <= S_BIT;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_index = r_rx_index;
  assign scl      = r_scl;

endmodule
